triangle_assembler: RTL and testbench

Read-side consumer of the geometry vertex FIFO. Pops packed vertices, groups every three into a triangle, and computes the signed doubled area and a screen-clamped bounding box. Culls back-facing, degenerate and fully off-screen triangles, and presents surviving triangles to the rasterizer on a valid/ready handshake.

---
 rtl/triangle_assembler_if.sv | 34 +++
 rtl/triangle_assembler.sv | 163 ++++++++++++++++
 tb/tb_triangle_assembler.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/triangle_assembler_if.sv
// rtl/triangle_assembler_if.sv - vertex FIFO read port and triangle output bundle
//   i_fifo_empty / i_fifo_data / o_fifo_re : vertex FIFO read side
//   o_tri_valid / i_tri_ready / o_tri_data  : triangle handshake to rasterizer
//   o_area, o_bbox_*                        : triangle sideband (area, clamped bbox)
//   o_cull_cnt                              : culled-triangle counter
//   master = assembler side, slave = FIFO/rasterizer side
interface triangle_assembler_if #(
  parameter int DATA_WIDTH = 104
);
  logic                      i_fifo_empty;
  logic [DATA_WIDTH-1:0]     i_fifo_data;
  logic                      o_fifo_re;
  logic                      o_tri_valid;
  logic                      i_tri_ready;
  logic [3*DATA_WIDTH-1:0]   o_tri_data;
  logic [34:0]               o_area;
  logic [15:0]               o_bbox_xmin;
  logic [15:0]               o_bbox_xmax;
  logic [15:0]               o_bbox_ymin;
  logic [15:0]               o_bbox_ymax;
  logic [15:0]               o_cull_cnt;

  modport master (
    input  i_fifo_empty, i_fifo_data, i_tri_ready,
    output o_fifo_re, o_tri_valid, o_tri_data, o_area,
           o_bbox_xmin, o_bbox_xmax, o_bbox_ymin, o_bbox_ymax, o_cull_cnt
  );

  modport slave (
    output i_fifo_empty, i_fifo_data, i_tri_ready,
    input  o_fifo_re, o_tri_valid, o_tri_data, o_area,
           o_bbox_xmin, o_bbox_xmax, o_bbox_ymin, o_bbox_ymax, o_cull_cnt
  );
endinterface

// File: rtl/triangle_assembler.sv
// rtl/triangle_assembler.sv - groups FIFO vertices into triangles, culls, emits with area and bbox
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : triangle_assembler_if.master (FIFO pop side, triangle valid/ready side)
module triangle_assembler #(
  parameter int DATA_WIDTH = 104,
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240,
  parameter bit CULL_EN    = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  triangle_assembler_if.master bus
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_AREA    = 3'd2;
  localparam logic [2:0] S_DECIDE  = 3'd3;
  localparam logic [2:0] S_OUT     = 3'd4;

  localparam logic signed [15:0] XMAX = 16'(SCREEN_W - 1);
  localparam logic signed [15:0] YMAX = 16'(SCREEN_H - 1);

  logic [2:0]                  state_q, state_d;
  logic [1:0]                  idx_q, idx_d;
  logic [2:0][DATA_WIDTH-1:0]  vtx_q;
  logic signed [34:0]          area_q;
  logic signed [15:0]          min_x_q, max_x_q, min_y_q, max_y_q;
  logic [15:0]                 xmin_q, xmax_q, ymin_q, ymax_q;
  logic [15:0]                 cull_cnt_q;

  function automatic logic signed [15:0] min3(input logic signed [15:0] a, b, c);
    logic signed [15:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [15:0] max3(input logic signed [15:0] a, b, c);
    logic signed [15:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic [15:0] clamp(input logic signed [15:0] v, input logic signed [15:0] hi);
    if (v < 16'sd0)  return 16'd0;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  logic signed [15:0] x0, x1, x2, y0, y1, y2;
  assign x0 = vtx_q[0][DATA_WIDTH-1  -: 16];
  assign x1 = vtx_q[1][DATA_WIDTH-1  -: 16];
  assign x2 = vtx_q[2][DATA_WIDTH-1  -: 16];
  assign y0 = vtx_q[0][DATA_WIDTH-17 -: 16];
  assign y1 = vtx_q[1][DATA_WIDTH-17 -: 16];
  assign y2 = vtx_q[2][DATA_WIDTH-17 -: 16];

  // Full-precision area: 17-bit differences, 34-bit products, 35-bit result.
  logic signed [16:0] dx1, dy1, dx2, dy2;
  logic signed [33:0] p_a, p_b;
  logic signed [34:0] area_d;
  assign dx1    = {x1[15], x1} - {x0[15], x0};
  assign dy1    = {y1[15], y1} - {y0[15], y0};
  assign dx2    = {x2[15], x2} - {x0[15], x0};
  assign dy2    = {y2[15], y2} - {y0[15], y0};
  assign p_a    = dx1 * dy2;
  assign p_b    = dx2 * dy1;
  assign area_d = {p_a[33], p_a} - {p_b[33], p_b};

  // Cull decision works on the unclamped box so partially visible triangles survive.
  logic area_nonpos, offscreen, cull;
  assign area_nonpos = area_q[34] || (area_q == '0);
  assign offscreen   = (max_x_q < 16'sd0) || (min_x_q > XMAX) ||
                       (max_y_q < 16'sd0) || (min_y_q > YMAX);
  assign cull        = (CULL_EN && area_nonpos) || offscreen;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_FETCH:   if (!bus.i_fifo_empty) state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (idx_q == 2'd2) begin
          state_d = S_AREA;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_FETCH;
        end
      end
      S_AREA:    state_d = S_DECIDE;
      S_DECIDE: begin
        if (cull) begin
          idx_d   = '0;
          state_d = S_FETCH;
        end else begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.i_tri_ready) begin
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_FETCH;
      idx_q      <= '0;
      vtx_q      <= '0;
      area_q     <= '0;
      min_x_q    <= '0;
      max_x_q    <= '0;
      min_y_q    <= '0;
      max_y_q    <= '0;
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymin_q     <= '0;
      ymax_q     <= '0;
      cull_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == S_CAPTURE) vtx_q[idx_q] <= bus.i_fifo_data;
      if (state_q == S_AREA) begin
        area_q  <= area_d;
        min_x_q <= min3(x0, x1, x2);
        max_x_q <= max3(x0, x1, x2);
        min_y_q <= min3(y0, y1, y2);
        max_y_q <= max3(y0, y1, y2);
      end
      if (state_q == S_DECIDE) begin
        if (cull) begin
          cull_cnt_q <= cull_cnt_q + 16'd1;
        end else begin
          xmin_q <= clamp(min_x_q, XMAX);
          xmax_q <= clamp(max_x_q, XMAX);
          ymin_q <= clamp(min_y_q, YMAX);
          ymax_q <= clamp(max_y_q, YMAX);
        end
      end
    end
  end

  // Pop is gated by reset so the FIFO is never drained while the block is held in reset.
  assign bus.o_fifo_re   = i_rst_n && (state_q == S_FETCH) && !bus.i_fifo_empty;
  assign bus.o_tri_valid = (state_q == S_OUT);
  assign bus.o_tri_data  = vtx_q;
  assign bus.o_area      = area_q;
  assign bus.o_bbox_xmin = xmin_q;
  assign bus.o_bbox_xmax = xmax_q;
  assign bus.o_bbox_ymin = ymin_q;
  assign bus.o_bbox_ymax = ymax_q;
  assign bus.o_cull_cnt  = cull_cnt_q;

endmodule

// File: tb/tb_triangle_assembler.sv
// tb/tb_triangle_assembler.sv - bench for triangle_assembler (culling and non-culling instances)
module tb_triangle_assembler;
  localparam int DW = 104;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  triangle_assembler_if #(.DATA_WIDTH(DW)) bus0 ();
  triangle_assembler_if #(.DATA_WIDTH(DW)) bus1 ();

  triangle_assembler #(.DATA_WIDTH(DW), .SCREEN_W(320), .SCREEN_H(240), .CULL_EN(1'b1))
    dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
  triangle_assembler #(.DATA_WIDTH(DW), .SCREEN_W(320), .SCREEN_H(240), .CULL_EN(1'b0))
    dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

  // shared vertex FIFO contents, separate read pointers per instance
  logic [DW-1:0] mem [0:1023];
  int            wr_ptr = 0;
  int            rd_ptr [2] = '{0, 0};
  logic [DW-1:0] rd_data [2] = '{default: '0};
  logic          ready = 1'b1;
  int            ready_mode = 0;

  assign bus0.i_fifo_empty = (rd_ptr[0] == wr_ptr);
  assign bus1.i_fifo_empty = (rd_ptr[1] == wr_ptr);
  assign bus0.i_fifo_data  = rd_data[0];
  assign bus1.i_fifo_data  = rd_data[1];
  assign bus0.i_tri_ready  = ready;
  assign bus1.i_tri_ready  = ready;

  always @(posedge clk) begin
    if (bus0.o_fifo_re) begin rd_data[0] <= mem[rd_ptr[0]]; rd_ptr[0] <= rd_ptr[0] + 1; end
    if (bus1.o_fifo_re) begin rd_data[1] <= mem[rd_ptr[1]]; rd_ptr[1] <= rd_ptr[1] + 1; end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       ready = 1'b1;
        1:       ready = 1'($urandom_range(0, 1));
        default: ready = 1'b0;
      endcase
    end
  end

  logic          re_w [2], vld_w [2], emp_w [2];
  logic [3*DW-1:0] dat_w [2];
  logic [34:0]   area_w [2];
  logic [63:0]   bb_w [2];
  logic [15:0]   cc_w [2];
  assign re_w[0] = bus0.o_fifo_re;     assign re_w[1] = bus1.o_fifo_re;
  assign vld_w[0] = bus0.o_tri_valid;  assign vld_w[1] = bus1.o_tri_valid;
  assign emp_w[0] = bus0.i_fifo_empty; assign emp_w[1] = bus1.i_fifo_empty;
  assign dat_w[0] = bus0.o_tri_data;   assign dat_w[1] = bus1.o_tri_data;
  assign area_w[0] = bus0.o_area;      assign area_w[1] = bus1.o_area;
  assign cc_w[0] = bus0.o_cull_cnt;    assign cc_w[1] = bus1.o_cull_cnt;
  assign bb_w[0] = {bus0.o_bbox_xmin, bus0.o_bbox_xmax, bus0.o_bbox_ymin, bus0.o_bbox_ymax};
  assign bb_w[1] = {bus1.o_bbox_xmin, bus1.o_bbox_xmax, bus1.o_bbox_ymin, bus1.o_bbox_ymax};

  // monitor: records pops, valid rises, transfers and protocol violations
  int              cyc = 0;
  int              npop [2] = '{0, 0};
  int              ntri [2] = '{0, 0};
  int              bad_pop [2] = '{0, 0};
  int              bad_stall [2] = '{0, 0};
  int              bad_drop [2] = '{0, 0};
  int              pop_cyc [2][256];
  int              rise_cyc [2][128];
  logic [3*DW-1:0] obs_data [2][128];
  longint          obs_area [2][128];
  logic [63:0]     obs_bb [2][128];
  logic            pv [2] = '{1'b0, 1'b0};
  logic            pr [2] = '{1'b0, 1'b0};
  logic [3*DW-1:0] ps_data [2];
  logic [34:0]     ps_area [2];
  logic [63:0]     ps_bb [2];

  always @(negedge clk) begin
    cyc++;
    for (int n = 0; n < 2; n++) begin
      if (!rst_n) begin
        pv[n] = 1'b0;
        pr[n] = 1'b0;
      end else begin
        if (re_w[n] && emp_w[n]) bad_pop[n]++;
        if (re_w[n] && vld_w[n]) bad_stall[n]++;
        if (re_w[n]) begin
          if (npop[n] < 256) pop_cyc[n][npop[n]] = cyc;
          npop[n]++;
        end
        if (pv[n] && !pr[n] && (!vld_w[n] || dat_w[n] != ps_data[n] ||
            area_w[n] != ps_area[n] || bb_w[n] != ps_bb[n])) bad_stall[n]++;
        if (pv[n] && pr[n] && vld_w[n]) bad_drop[n]++;
        if (vld_w[n] && !pv[n] && ntri[n] < 128) rise_cyc[n][ntri[n]] = cyc;
        if (vld_w[n] && ready) begin
          if (ntri[n] < 128) begin
            obs_data[n][ntri[n]] = dat_w[n];
            obs_area[n][ntri[n]] = longint'($signed(area_w[n]));
            obs_bb[n][ntri[n]]   = bb_w[n];
          end
          ntri[n]++;
        end
        pv[n] = vld_w[n];
        pr[n] = ready;
        ps_data[n] = dat_w[n];
        ps_area[n] = area_w[n];
        ps_bb[n]   = bb_w[n];
      end
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: plain integer geometry on each group of three pushed vertices
  logic [DW-1:0]   mbuf [$];
  logic [3*DW-1:0] exp_data [2][128];
  longint          exp_area [2][128];
  logic [63:0]     exp_bb [2][128];
  int              nexp [2] = '{0, 0};
  int              exp_cull [2] = '{0, 0};

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [63:0] bbv(input int a, input int b, input int c, input int d);
    return {16'(a), 16'(b), 16'(c), 16'(d)};
  endfunction

  function automatic logic [DW-1:0] mkv(input int x, input int y);
    logic [15:0] xs, ys;
    xs = 16'(x);
    ys = 16'(y);
    return {xs, ys, 8'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  task automatic model_tri();
    int x [3], y [3];
    int mnx, mxx, mny, mxy;
    longint area;
    bit off, c;
    for (int i = 0; i < 3; i++) begin
      x[i] = int'($signed(mbuf[i][103:88]));
      y[i] = int'($signed(mbuf[i][87:72]));
    end
    area = longint'(x[1] - x[0]) * longint'(y[2] - y[0]) - longint'(x[2] - x[0]) * longint'(y[1] - y[0]);
    mnx = x[0]; mxx = x[0]; mny = y[0]; mxy = y[0];
    for (int i = 1; i < 3; i++) begin
      if (x[i] < mnx) mnx = x[i];
      if (x[i] > mxx) mxx = x[i];
      if (y[i] < mny) mny = y[i];
      if (y[i] > mxy) mxy = y[i];
    end
    off = (mxx < 0) || (mnx >= 320) || (mxy < 0) || (mny >= 240);
    for (int n = 0; n < 2; n++) begin
      c = off || (n == 0 && area <= 0);
      if (c) begin
        exp_cull[n]++;
      end else if (nexp[n] < 128) begin
        exp_data[n][nexp[n]] = {mbuf[2], mbuf[1], mbuf[0]};
        exp_area[n][nexp[n]] = area;
        exp_bb[n][nexp[n]]   = bbv(clampi(mnx, 319), clampi(mxx, 319), clampi(mny, 239), clampi(mxy, 239));
        nexp[n]++;
      end else begin
        nexp[n]++;
      end
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_v(input logic [DW-1:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
    mbuf.push_back(v);
    if (mbuf.size() == 3) begin
      model_tri();
      mbuf.delete();
    end
  endtask

  task automatic push_tri(input int xa, ya, xb, yb, xc, yc);
    push_v(mkv(xa, ya));
    push_v(mkv(xb, yb));
    push_v(mkv(xc, yc));
  endtask

  task automatic wait_idle(input string tag, input int limit);
    bit done;
    int k;
    done = 1'b0;
    k = 0;
    while (!done && k < limit) begin
      tick(1);
      k++;
      done = (rd_ptr[0] == wr_ptr) && (rd_ptr[1] == wr_ptr) &&
             (ntri[0] == nexp[0]) && (ntri[1] == nexp[1]);
    end
    check_eq(tag, 320'(done), 320'(1));
    tick(8);
  endtask

  initial begin
    logic [DW-1:0] va, vb, vc;
    int p;
    bit seen;

    rst_n = 1'b0;
    tick(3);
    check_eq("rst_valid", 320'(bus0.o_tri_valid), 320'(0));
    check_eq("rst_fifo_re", 320'(bus0.o_fifo_re), 320'(0));
    check_eq("rst_area", 320'(bus0.o_area), 320'(0));
    check_eq("rst_bbox", 320'(bb_w[0]), 320'(0));
    check_eq("rst_cull_cnt", 320'(bus0.o_cull_cnt), 320'(0));
    check_eq("rst_tri_data", 320'(bus0.o_tri_data), 320'(0));
    rst_n = 1'b1;

    tick(20);
    check_eq("empty_no_pop", 320'(npop[0] + npop[1]), 320'(0));

    push_tri(0, 0, 10, 0, 0, 10);
    wait_idle("t1_drain", 200);
    check_eq("t1_area", 320'(obs_area[0][0]), 320'(100));
    check_eq("t1_bbox", 320'(obs_bb[0][0]), 320'(bbv(0, 10, 0, 10)));
    check_eq("t1_latency", 320'(rise_cyc[0][0] - pop_cyc[0][2]), 320'(4));
    check_eq("t1_cull_cnt", 320'(cc_w[0]), 320'(0));

    push_tri(0, 0, 0, 10, 10, 0);
    wait_idle("t2_drain", 200);
    check_eq("t2_cull_cnt", 320'(cc_w[0]), 320'(1));
    check_eq("t2_no_emit", 320'(ntri[0]), 320'(1));
    check_eq("t2_noncull_area", 320'(obs_area[1][1]), 320'(-100));

    push_tri(-5, -5, 400, 0, 0, 300);
    wait_idle("t3_drain", 200);
    check_eq("t3_area", 320'(obs_area[0][1]), 320'(123500));
    check_eq("t3_bbox", 320'(obs_bb[0][1]), 320'(bbv(0, 319, 0, 239)));

    push_tri(400, 10, 500, 10, 400, 20);
    wait_idle("t4_drain", 200);
    check_eq("t4_cull_cnt0", 320'(cc_w[0]), 320'(2));
    check_eq("t4_cull_cnt1", 320'(cc_w[1]), 320'(1));
    check_eq("t4_no_emit", 320'(ntri[0]), 320'(2));

    ready_mode = 2;
    tick(3);
    push_tri(10, 10, 50, 10, 10, 50);
    push_tri(30, 30, 90, 30, 30, 90);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick(1);
      seen = vld_w[0];
    end
    check_eq("stall_valid_seen", 320'(seen), 320'(1));
    p = npop[0];
    tick(5);
    check_eq("stall_no_pop", 320'(npop[0]), 320'(p));
    check_eq("stall_valid_held", 320'(vld_w[0]), 320'(1));
    ready_mode = 0;
    wait_idle("stall_drain", 200);
    check_eq("stall_next_pops", 320'(npop[0]), 320'(p + 3));

    push_v(mkv(5, 5));
    push_v(mkv(70, 5));
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick(1);
      seen = (rd_ptr[0] == wr_ptr) && (rd_ptr[1] == wr_ptr);
    end
    check_eq("rst_mid_popped", 320'(seen), 320'(1));
    tick(3);
    rst_n = 1'b0;
    mbuf.delete();
    exp_cull = '{0, 0};
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check_eq("rst_mid_cull_cnt", 320'(cc_w[0]), 320'(0));
    va = mkv(20, 20);
    vb = mkv(60, 20);
    vc = mkv(20, 60);
    push_v(va);
    push_v(vb);
    push_v(vc);
    wait_idle("rst_mid_drain", 200);
    check_eq("rst_mid_data", 320'(obs_data[0][ntri[0] - 1]), 320'({vc, vb, va}));

    ready_mode = 1;
    for (int t = 0; t < 60; t++) begin
      for (int k = 0; k < 3; k++) begin
        push_v(mkv(int'($urandom_range(0, 520)) - 100, int'($urandom_range(0, 440)) - 100));
        tick($urandom_range(0, 3));
      end
    end
    ready_mode = 0;
    wait_idle("rand_drain", 4000);

    for (int n = 0; n < 2; n++) begin
      check_eq($sformatf("tri_count%0d", n), 320'(ntri[n]), 320'(nexp[n]));
      for (int i = 0; i < ntri[n] && i < nexp[n] && i < 128; i++) begin
        check_eq($sformatf("data%0d_%0d", n, i), 320'(obs_data[n][i]), 320'(exp_data[n][i]));
        check_eq($sformatf("area%0d_%0d", n, i), 320'(obs_area[n][i]), 320'(exp_area[n][i]));
        check_eq($sformatf("bbox%0d_%0d", n, i), 320'(obs_bb[n][i]), 320'(exp_bb[n][i]));
      end
      check_eq($sformatf("cull_cnt%0d", n), 320'(cc_w[n]), 320'(16'(exp_cull[n])));
      check_eq($sformatf("pop_when_empty%0d", n), 320'(bad_pop[n]), 320'(0));
      check_eq($sformatf("stall_violation%0d", n), 320'(bad_stall[n]), 320'(0));
      check_eq($sformatf("valid_after_xfer%0d", n), 320'(bad_drop[n]), 320'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
